// File: rtl/als_pkg.sv
// rtl/als_pkg.sv - ALS ADC frame geometry, FSM encoding and frame packing shared with the master
package als_pkg;

  localparam int FRAME_BITS  = 16;
  localparam int LEAD_ZEROS  = 3;
  localparam int DATA_W      = 8;
  localparam int TRAIL_ZEROS = FRAME_BITS - LEAD_ZEROS - DATA_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    TAIL  = 2'd2
  } als_state_e;

  // Frame word: leading zeros, sample MSB-first, trailing zeros.
  function automatic logic [FRAME_BITS-1:0] pack_frame(input logic [DATA_W-1:0] data);
    logic [FRAME_BITS-1:0] f;
    f = '0;
    f[FRAME_BITS-1-LEAD_ZEROS -: DATA_W] = data;
    return f;
  endfunction

endpackage

// File: rtl/als_adc_responder_if.sv
// rtl/als_adc_responder_if.sv - SPI pins and host sample/status signals of the ALS ADC responder
interface als_adc_responder_if;
  import als_pkg::*;

  logic              cs_n;
  logic              sclk;
  logic              sdo;
  logic              sdo_oe;
  logic [DATA_W-1:0] sample;
  logic              sample_valid;
  logic              busy;
  logic              frame_done;
  logic              frame_abort;
  logic              quiet_err;

  modport slave (
    input  cs_n, sclk, sample, sample_valid,
    output sdo, sdo_oe, busy, frame_done, frame_abort, quiet_err
  );

  modport master (
    output cs_n, sclk, sample, sample_valid,
    input  sdo, sdo_oe, busy, frame_done, frame_abort, quiet_err
  );

endinterface

// File: rtl/spi_in_sync.sv
// rtl/spi_in_sync.sv - multi-stage synchronizer with single-cycle rise/fall detect
module spi_in_sync #(
  parameter int   STAGES     = 2,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      chain <= {STAGES{IDLE_LEVEL}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  // Edges compare the two oldest stages; q is the older of the pair.
  assign q    = chain[STAGES-1];
  assign rise = ~chain[STAGES-1] &  chain[STAGES-2];
  assign fall =  chain[STAGES-1] & ~chain[STAGES-2];

endmodule

// File: rtl/als_adc_responder.sv
// rtl/als_adc_responder.sv - SPI responder emulating the ambient-light-sensor ADC frame on sdo
module als_adc_responder
  import als_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int QUIET_MIN   = 4
) (
  input logic               clk,
  input logic               resetn,
  als_adc_responder_if.slave bus
);

  localparam int CNT_W = $clog2(FRAME_BITS);
  localparam int QW    = $clog2(QUIET_MIN + 1);

  logic cs_q, cs_rise, cs_fall;
  logic sclk_fall, sclk_unused_q, sclk_unused_rise;

  als_state_e state, next_state;

  logic [FRAME_BITS-1:0] shreg;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_W-1:0]     holding;
  logic [DATA_W-1:0]     snapshot;
  logic [QW-1:0]         quiet_cnt;
  logic                  last_bit;

  spi_in_sync #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_cs_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (bus.cs_n),
    .q      (cs_q),
    .rise   (cs_rise),
    .fall   (cs_fall)
  );

  spi_in_sync #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_sclk_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (bus.sclk),
    .q      (sclk_unused_q),
    .rise   (sclk_unused_rise),
    .fall   (sclk_fall)
  );

  assign last_bit = (bit_cnt == CNT_W'(FRAME_BITS - 1));
  // A sample arriving in the cs_fall cycle wins over the held value.
  assign snapshot = bus.sample_valid ? bus.sample : holding;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (cs_fall) next_state = SHIFT;
      SHIFT: begin
        if (cs_rise)                    next_state = IDLE;
        else if (sclk_fall && last_bit) next_state = TAIL;
      end
      TAIL:    if (cs_rise) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shreg     <= '0;
      bit_cnt   <= '0;
      holding   <= '0;
      quiet_cnt <= QW'(QUIET_MIN);
    end else begin
      if (bus.sample_valid) begin
        holding <= bus.sample;
      end
      if (cs_q) begin
        if (quiet_cnt < QW'(QUIET_MIN)) quiet_cnt <= quiet_cnt + 1'b1;
      end else begin
        quiet_cnt <= '0;
      end
      if (state == IDLE && cs_fall) begin
        shreg   <= pack_frame(snapshot);
        bit_cnt <= '0;
      end else if (state == SHIFT && !cs_rise && sclk_fall && !last_bit) begin
        shreg   <= {shreg[FRAME_BITS-2:0], 1'b0};
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    bus.sdo         = 1'b0;
    bus.sdo_oe      = 1'b0;
    bus.busy        = 1'b0;
    bus.frame_done  = 1'b0;
    bus.frame_abort = 1'b0;
    bus.quiet_err   = cs_fall && (quiet_cnt < QW'(QUIET_MIN));
    case (state)
      SHIFT: begin
        bus.sdo         = shreg[FRAME_BITS-1];
        bus.sdo_oe      = 1'b1;
        bus.busy        = 1'b1;
        bus.frame_done  = !cs_rise && sclk_fall && last_bit;
        bus.frame_abort = cs_rise;
      end
      TAIL: begin
        bus.sdo_oe = 1'b1;
        bus.busy   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/als_adc_responder.md
Name: als_adc_responder

Overview:
- SPI responder that emulates the ambient-light-sensor ADC: 8-bit sample, 16-clock frame, data on sdo.
- Answers the ALS SPI master in loopback and system simulation, so the light path can be tested without the Pmod.
- Oversamples the master's cs_n/sclk on the local clock and shifts out a frame built from a host-supplied sample.

Parameters:
- SYNC_STAGES, 2, synchronizer depth on cs_n and sclk inputs (min 2).
- FRAME_BITS, 16, sclk cycles per frame.
- LEAD_ZEROS, 3, zero bits before the data MSB.
- DATA_W, 8, sample width; trailing zeros = FRAME_BITS-LEAD_ZEROS-DATA_W (5).
- QUIET_MIN, 4, minimum clk cycles cs_n must stay high between frames.

Ports:
- clk  in  1  local clock; all logic on its rising edge.
- resetn  in  1  asynchronous active-low reset.
- cs_n  in  1  chip select from master, asynchronous to clk.
- sclk  in  1  serial clock from master, asynchronous to clk.
- sdo  out  1  serial data to master.
- sdo_oe  out  1  high while responder drives sdo (tristate enable at pad).
- sample  in  DATA_W  next conversion value.
- sample_valid  in  1  one-cycle strobe; loads sample into holding register.
- busy  out  1  high while a frame is in progress.
- frame_done  out  1  one-cycle pulse after FRAME_BITS bits shifted.
- frame_abort  out  1  one-cycle pulse when cs_n rises early.
- quiet_err  out  1  one-cycle pulse when cs_n falls before QUIET_MIN high cycles.

Behaviour:
- Reset (async assert, sync deassert): sdo=0, sdo_oe=0, busy=0, all pulses 0, holding=0, state IDLE, sync chains at idle level (cs_n=1, sclk=1).
- Timing limit: each sclk half-period must be at least SYNC_STAGES+2 clk cycles. Faster sclk is unsupported and unchecked.
- Edge detect: cs_fall, cs_rise and sclk_fall come from the last two synchronizer stages. Each edge is one clk pulse.
- Holding register: loads on sample_valid at any time. A frame shifts a snapshot taken at cs_fall, so a mid-frame sample_valid never alters the frame in flight.
- Frame word: {LEAD_ZEROS x 0, snapshot MSB-first, trailing zeros}. Default layout is bits 15..13 = 0, 12..5 = data, 4..0 = 0.
- State IDLE:
  - On cs_fall: load the shift register with the frame word, set bit_cnt=0, set sdo=frame[15], assert sdo_oe and busy, go to SHIFT.
  - sdo is valid 1 clk after cs_fall is detected.
- State SHIFT:
  - On each sclk_fall, shift left and present the next bit; sdo updates 1 clk after the detected edge. bit_cnt increments.
  - The falling edge that completes bit FRAME_BITS-1 (bit_cnt reaches FRAME_BITS-1 and that bit's hold period ends): pulse frame_done, drive sdo=0, go to TAIL.
- State TAIL: drives 0 on further sclk edges. On cs_rise: deassert sdo_oe and busy, go to IDLE.
- Early cs_rise in SHIFT (bit_cnt < FRAME_BITS-1):
  - Pulse frame_abort; sdo_oe=0, busy=0, sdo=0; go to IDLE.
  - frame_done is not pulsed.
- Quiet counter:
  - Counts clk cycles while the synchronized cs_n is high, saturating at QUIET_MIN.
  - A cs_fall with count < QUIET_MIN pulses quiet_err. The frame still starts normally.
  - No quiet_err on the first frame after reset: the counter resets to QUIET_MIN.
- sclk edges while in IDLE are ignored.
- cs_fall and sample_valid in the same cycle: the snapshot takes the new sample (bypass).
- Reset mid-frame: immediate return to reset values; the next frame needs a fresh cs_fall.

Decomposition:
- Package als_pkg holds:
  - FRAME_BITS, LEAD_ZEROS, DATA_W defaults, shared with the master.
  - State encoding IDLE/SHIFT/TAIL.
  - A frame-pack function.
- Sub-module spi_in_sync: parameterised synchronizer plus rise/fall detector. Instantiated for cs_n and sclk.

Test Plan:
- Basic frame: sample=0xA5, cs_n low, 16 sclk cycles at 10 clk per period. Master samples on rising sclk and receives 0x14A0; data field = 0xA5; frame_done pulses once; sdo_oe low 1-3 clk after cs_n rises.
- Back-to-back: sample 0xFF then 0x00 with 20 clk quiet gap. Frames decode 0xFF then 0x00; no quiet_err.
- Mid-frame update: sample_valid with 0x3C during bit 7 of a 0xC3 frame. Current frame returns 0xC3, next frame returns 0x3C.
- Abort: cs_n rises after 9 sclk falls. frame_abort pulses once with no frame_done; busy=0. The next frame with 0x81 decodes correctly.
- Quiet violation: cs_n high only 2 clk between frames. quiet_err pulses once and the second frame is still correct.
- Async reset asserted mid-SHIFT: all outputs zero in the same cycle. After release, an sclk toggle with cs_n high produces no output activity.
